// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with a 2-entry (main + skid) valid/ready buffer,
// capture-time shift-amount decode, synchronous flush and a saturating stall counter.
`timescale 1ns/1ps

module id_ex_reg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_pc,
  input  logic [DATA_W-1:0]  in_rs1_data,
  input  logic [DATA_W-1:0]  in_rs2_data,
  input  logic [DATA_W-1:0]  in_imm,
  input  logic               in_use_imm,
  input  logic [3:0]         in_alu_op,
  input  logic [4:0]         in_rd_addr,
  input  logic               in_reg_wen,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_pc,
  output logic [DATA_W-1:0]  out_rs1,
  output logic [DATA_W-1:0]  out_rs2,
  output logic [DATA_W-1:0]  out_imm,
  output logic [SHAMT_W-1:0] out_shamt,
  output logic [3:0]         out_alu_op,
  output logic [4:0]         out_rd_addr,
  output logic               out_reg_wen,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0]  pc;
    logic [DATA_W-1:0]  rs1;
    logic [DATA_W-1:0]  rs2;
    logic [DATA_W-1:0]  imm;
    logic [SHAMT_W-1:0] shamt;
    logic [3:0]         alu_op;
    logic [4:0]         rd;
    logic               wen;
  } entry_t;

  entry_t           r_main;
  entry_t           r_skid;
  logic             r_main_valid;
  logic             r_skid_valid;
  logic [CNT_W-1:0] r_stall_cnt;

  entry_t w_in;
  logic   w_accept;
  logic   w_xfer;

  // Shift amount is resolved here so EX sees a single field for both forms.
  always_comb begin
    w_in        = '0;
    w_in.pc     = in_pc;
    w_in.rs1    = in_rs1_data;
    w_in.rs2    = in_rs2_data;
    w_in.imm    = in_imm;
    w_in.shamt  = in_use_imm ? in_imm[SHAMT_W-1:0] : in_rs2_data[SHAMT_W-1:0];
    w_in.alu_op = in_alu_op;
    w_in.rd     = in_rd_addr;
    w_in.wen    = in_reg_wen;
  end

  assign in_ready = !r_skid_valid;
  assign w_accept = in_valid && in_ready;
  assign w_xfer   = r_main_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid || (w_xfer && !r_skid_valid)) begin
      r_main_valid <= w_accept;
      if (w_accept) r_main <= w_in;
    end else if (w_xfer) begin
      // Skid was full, so in_ready was low and no input competes this cycle.
      r_main       <= r_skid;
      r_skid_valid <= 1'b0;
    end else if (w_accept) begin
      r_skid       <= w_in;
      r_skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_main_valid && !out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign out_valid   = r_main_valid;
  assign out_pc      = r_main.pc;
  assign out_rs1     = r_main.rs1;
  assign out_rs2     = r_main.rs2;
  assign out_imm     = r_main.imm;
  assign out_shamt   = r_main.shamt;
  assign out_alu_op  = r_main.alu_op;
  assign out_rd_addr = r_main.rd;
  assign out_reg_wen = r_main.wen && r_main_valid;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: driver pushes hand-computed expectations on accept,
// a negedge monitor pops and compares on every output transfer.
`timescale 1ns/1ps

module tb_id_ex_reg;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic        in_use_imm;
  logic [3:0]  in_alu_op;
  logic [4:0]  in_rd_addr;
  logic        in_reg_wen;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc, out_rs1, out_rs2, out_imm;
  logic [4:0]  out_shamt;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rd_addr;
  logic        out_reg_wen;
  logic [15:0] stall_cnt;

  id_ex_reg #(.DATA_W(32), .SHAMT_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_alu_op(in_alu_op),
    .in_rd_addr(in_rd_addr), .in_reg_wen(in_reg_wen),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_shamt(out_shamt), .out_alu_op(out_alu_op), .out_rd_addr(out_rd_addr),
    .out_reg_wen(out_reg_wen), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [31:0] pc, rs1, rs2, imm;
    logic [4:0]  shamt;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        wen;
  } exp_t;

  exp_t q[$];
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, want completion)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compare on transfer first, then drop held entries on flush/reset.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_output_pc", out_pc, 64'hDEAD_0000);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_pc", out_pc, e.pc);
        chk("sb_rs1", out_rs1, e.rs1);
        chk("sb_rs2", out_rs2, e.rs2);
        chk("sb_imm", out_imm, e.imm);
        chk("sb_shamt", out_shamt, e.shamt);
        chk("sb_alu_op", out_alu_op, e.op);
        chk("sb_rd", out_rd_addr, e.rd);
        chk("sb_reg_wen", out_reg_wen, e.wen);
      end
    end
    if (!rst_n || flush) q.delete();
  end

  task automatic drive(input logic [31:0] pc, rs1, rs2, imm, input logic use_imm,
                       input logic [3:0] op, input logic [4:0] rd, input logic wen);
    in_pc = pc; in_rs1_data = rs1; in_rs2_data = rs2; in_imm = imm;
    in_use_imm = use_imm; in_alu_op = op; in_rd_addr = rd; in_reg_wen = wen;
  endtask

  task automatic send(input logic [31:0] pc, rs1, rs2, imm, input logic use_imm,
                      input logic [3:0] op, input logic [4:0] rd, input logic wen,
                      input logic [4:0] shamt);
    int unsigned g;
    exp_t e;
    drive(pc, rs1, rs2, imm, use_imm, op, rd, wen);
    in_valid = 1'b1;
    @(negedge clk);
    g = 0;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
    end else begin
      e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
      e.shamt = shamt; e.op = op; e.rd = rd; e.wen = wen;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive('0, '0, '0, '0, 1'b0, 4'h0, 5'd0, 1'b0);
    cycles(2);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_reg_wen", out_reg_wen, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    rst_n = 1'b1;
    cycles(1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid_after", out_valid, 0);

    // Single entry, immediate form
    send(32'h100, 32'hF0, 32'h0, 32'h23, 1'b1, 4'h1, 5'd5, 1'b1, 5'd3);
    chk("single_out_valid", out_valid, 1);
    chk("single_shamt", out_shamt, 3);
    chk("single_rs1", out_rs1, 32'hF0);
    chk("single_reg_wen", out_reg_wen, 1);
    cycles(1);
    chk("single_out_valid_drop", out_valid, 0);

    // Register form: upper rs2 bits and imm ignored
    send(32'h104, 32'h1234_5678, 32'hFFFF_FFE7, 32'h1F, 1'b0, 4'h5, 5'd6, 1'b0, 5'd7);
    chk("regform_shamt", out_shamt, 7);
    chk("regform_reg_wen", out_reg_wen, 0);
    cycles(2);

    // Back-to-back stream
    send(32'h200, 32'h11, 32'h22, 32'h3A,        1'b1, 4'h2, 5'd1, 1'b1, 5'h1A);
    chk("stream_in_ready_a", in_ready, 1);
    send(32'h204, 32'h33, 32'h40, 32'h7,         1'b0, 4'h3, 5'd2, 1'b1, 5'h00);
    chk("stream_in_ready_b", in_ready, 1);
    send(32'h208, 32'h55, 32'hFFFF_FFFF, 32'h0,  1'b0, 4'h4, 5'd3, 1'b0, 5'h1F);
    chk("stream_in_ready_c", in_ready, 1);
    send(32'h20C, 32'h77, 32'h8, 32'hFFFF_FFE1,  1'b1, 4'h6, 5'd4, 1'b1, 5'h01);
    chk("stream_in_ready_d", in_ready, 1);
    chk("stream_out_pc_d", out_pc, 32'h20C);
    cycles(3);
    chk("stream_stall_cnt", stall_cnt, 0);

    // Back-pressure: A in main, B in skid, C held off
    out_ready = 1'b0;
    send(32'h300, 32'hA0, 32'h1, 32'h2, 1'b0, 4'h7, 5'd7, 1'b1, 5'd1);
    send(32'h304, 32'hB0, 32'h3, 32'h4, 1'b1, 4'h8, 5'd8, 1'b1, 5'd4);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_stall_1", stall_cnt, 1);
    chk("bp_out_pc_a", out_pc, 32'h300);
    drive(32'h308, 32'hC0, 32'h25, 32'h6, 1'b0, 4'h9, 5'd9, 1'b0);
    in_valid = 1'b1;
    cycles(3);
    chk("bp_stall_4", stall_cnt, 4);
    chk("bp_in_ready_still_low", in_ready, 0);
    chk("bp_out_pc_hold", out_pc, 32'h300);
    out_ready = 1'b1;
    send(32'h308, 32'hC0, 32'h25, 32'h6, 1'b0, 4'h9, 5'd9, 1'b0, 5'd5);
    cycles(3);
    chk("bp_stall_after", stall_cnt, 4);
    chk("bp_drained", out_valid, 0);

    // Flush with main and skid full, input presented in flush cycle
    out_ready = 1'b0;
    send(32'h400, 32'h1, 32'h2, 32'h3, 1'b0, 4'h1, 5'd10, 1'b1, 5'd2);
    send(32'h404, 32'h4, 32'h5, 32'h6, 1'b0, 4'h1, 5'd11, 1'b1, 5'd5);
    chk("fl1_in_ready_low", in_ready, 0);
    drive(32'h4F0, 32'h9, 32'h9, 32'h9, 1'b0, 4'hF, 5'd31, 1'b1);
    in_valid = 1'b1; flush = 1'b1;
    cycles(1);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl1_out_valid", out_valid, 0);
    chk("fl1_out_reg_wen", out_reg_wen, 0);
    chk("fl1_in_ready", in_ready, 1);
    chk("fl1_stall_kept", stall_cnt, 6);
    out_ready = 1'b1;
    cycles(3);
    chk("fl1_no_output", out_valid, 0);

    // Flush with skid free: flush-cycle input must still be discarded
    out_ready = 1'b0;
    send(32'h500, 32'h1, 32'h2, 32'h3, 1'b0, 4'h2, 5'd12, 1'b1, 5'd2);
    chk("fl2_in_ready", in_ready, 1);
    drive(32'h5F0, 32'h8, 32'h8, 32'h8, 1'b0, 4'hE, 5'd30, 1'b1);
    in_valid = 1'b1; flush = 1'b1;
    cycles(1);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl2_out_valid", out_valid, 0);
    chk("fl2_stall", stall_cnt, 7);
    out_ready = 1'b1;
    cycles(3);
    chk("fl2_no_output", out_valid, 0);
    send(32'h600, 32'hAB, 32'hCD, 32'h10, 1'b1, 4'h3, 5'd13, 1'b1, 5'h10);
    chk("post_flush_pc", out_pc, 32'h600);
    cycles(2);

    // Saturation then reset mid-operation
    out_ready = 1'b0;
    send(32'h700, 32'h70, 32'h71, 32'h72, 1'b1, 4'h4, 5'd14, 1'b1, 5'h12);
    cycles(70000);
    chk("sat_stall_cnt", stall_cnt, 16'hFFFF);
    chk("sat_out_valid", out_valid, 1);
    chk("sat_out_pc", out_pc, 32'h700);
    rst_n = 1'b0;
    cycles(1);
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_out_pc", out_pc, 0);
    chk("rst2_out_rs1", out_rs1, 0);
    chk("rst2_out_shamt", out_shamt, 0);
    chk("rst2_out_reg_wen", out_reg_wen, 0);
    chk("rst2_stall_cnt", stall_cnt, 0);
    rst_n = 1'b1;
    chk("rst2_in_ready", in_ready, 1);
    out_ready = 1'b1;
    cycles(2);
    chk("scoreboard_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register: captures decoded operands and control from the decode stage and presents them to the EX stage.
- Supplies rs1 data and the 5-bit shift amount consumed by the EX shifters, plus pass-through control.
- Valid/ready handshake on both sides with a 2-entry skid buffer, so EX back-pressure never drops an instruction.
- Includes a synchronous flush for branch redirect and a saturating stall counter.

Parameters:
- DATA_W, 32, operand/PC width.
- SHAMT_W, 5, shift-amount width; must equal log2(DATA_W).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  discard all held and incoming entries
- in_valid  in  1  decode presents an entry
- in_ready  out  1  register can accept
- in_pc  in  DATA_W  instruction PC
- in_rs1_data  in  DATA_W  rs1 operand
- in_rs2_data  in  DATA_W  rs2 operand
- in_imm  in  DATA_W  sign-extended immediate
- in_use_imm  in  1  1 = immediate form (SLLI/SRLI/SRAI), 0 = register form
- in_alu_op  in  4  ALU/shift opcode
- in_rd_addr  in  5  destination register
- in_reg_wen  in  1  writes rd
- out_valid  out  1  EX entry valid
- out_ready  in  1  EX accepts
- out_pc  out  DATA_W
- out_rs1  out  DATA_W
- out_rs2  out  DATA_W
- out_imm  out  DATA_W
- out_shamt  out  SHAMT_W  shift amount for EX shifters
- out_alu_op  out  4
- out_rd_addr  out  5
- out_reg_wen  out  1  gated: in_reg_wen of held entry AND out_valid
- stall_cnt  out  CNT_W  saturating back-pressure cycle count

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous, active-low.
- Reset (rst_n=0 at a clk edge) clears all state.
  - main_valid=0, skid_valid=0.
  - All data outputs 0; out_valid=0; out_reg_wen=0; stall_cnt=0.
  - Nothing is captured while rst_n=0. in_ready reads 1 after reset.
- Storage: main register drives all out_* ports; skid register holds one overflow entry. in_ready = !skid_valid, taken from a flop.
- Accept: in_valid && in_ready at the edge. Output transfer: out_valid && out_ready at the edge.
- Capture-time decode:
  - shamt = in_use_imm ? in_imm[SHAMT_W-1:0] : in_rs2_data[SHAMT_W-1:0].
  - Upper operand bits are ignored for shamt.
- Next-state rules (no flush, in priority order):
  - Main empty, or main transferring with skid empty: an accepted input loads main. out_valid rises the next cycle, so latency is 1 cycle.
  - Main transferring with skid full: skid moves to main and skid_valid clears. Skid was full, so in_ready=0 and no input is accepted that cycle.
  - Main full and not transferring: an accepted input loads skid, skid_valid sets, and in_ready drops the next cycle.
  - Main stays unchanged while out_valid && !out_ready. Held entries do not change while stalled.
- Ordering and throughput:
  - Strict in-order delivery.
  - With out_ready held 1, throughput is 1 entry/cycle and skid stays empty.
- Flush (synchronous, active-high, checked after reset):
  - Next cycle: main_valid=0, skid_valid=0, in_ready=1.
  - Any entry accepted or transferred in the flush cycle is discarded on the input side. An output transfer that cycle still counts as delivered to EX.
  - Data fields may keep stale values, but out_valid=0 and out_reg_wen=0.
- Stall counter:
  - Increments by 1 on each cycle with out_valid && !out_ready.
  - Saturates at all-ones.
  - Cleared only by reset; flush does not clear it.
- Reset mid-operation: buffered entries are lost, with no partial output.

Test Plan:
- Reset then single entry (pc=0x100, rs1=0xF0, use_imm=1, imm=0x23, wen=1) with out_ready=1 -> out_valid=1 one cycle later, out_shamt=3, out_rs1=0xF0, out_reg_wen=1; out_valid=0 the next cycle.
- Register form (use_imm=0, rs2=0xFFFF_FFE7) -> out_shamt=7.
- Back-to-back stream A,B,C,D, one per cycle, out_ready=1 -> outputs A..D on consecutive cycles; in_ready stays 1; stall_cnt=0.
- Back-pressure: send A,B with out_ready=0 -> A held in main, B in skid, in_ready=0, C held off; stall_cnt increments each cycle. Then raise out_ready -> A, B, C delivered in order.
- Flush with main and skid full, in_valid=1 in the flush cycle -> next cycle out_valid=0, in_ready=1; the flush-cycle input never appears at the output.
- Hold out_valid=1, out_ready=0 for 70000 cycles with CNT_W=16 -> stall_cnt=0xFFFF, no wrap. Assert rst_n=0 for 1 cycle -> all outputs 0, stall_cnt=0.
